// File: rtl/modulator_pkg.sv
// Shared widths, QPSK constellation levels and the I/Q bundle type.
// Used by the mapper and the modulator top.
package modulator_pkg;

    localparam int IQ_W = 16;

    localparam logic [IQ_W-1:0] QPSK_POS = 16'h5A7F;
    localparam logic [IQ_W-1:0] QPSK_NEG = 16'hA581;

    typedef struct packed {
        logic [IQ_W-1:0] i;
        logic [IQ_W-1:0] q;
    } iq_t;

    // Gray mapping per axis: bit 0 -> +0.707, bit 1 -> -0.707
    function automatic logic [IQ_W-1:0] qpsk_level(input logic b);
        return b ? QPSK_NEG : QPSK_POS;
    endfunction

endpackage

// File: rtl/qpsk_mapper.sv
// Combinational Gray QPSK mapper: b0 drives I, b1 drives Q.
// Pure lookup, no state.
module qpsk_mapper
    import modulator_pkg::*;
(
    input  logic i_b0,
    input  logic i_b1,
    output iq_t  o_iq
);

    always_comb begin
        o_iq   = '0;
        o_iq.i = qpsk_level(i_b0);
        o_iq.q = qpsk_level(i_b1);
    end

endmodule

// File: rtl/modulator.sv
// QPSK modulator: pairs serial bits, maps them, holds one output symbol.
// Optional MODULATOR_ZERO_IDLE_EN forces I/Q to zero while Valid_out is low.
module modulator
    import modulator_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            Valid_in,
    input  logic            Data_in,
    output logic            Ready_in,
    input  logic            Ready_out,
    output logic            Valid_out,
    output logic [IQ_W-1:0] I,
    output logic [IQ_W-1:0] Q
);

    logic r_phase;
    logic r_b0;
    logic r_valid;
    iq_t  r_iq;

    logic w_ready;
    logic w_accept;
    logic w_load;
    iq_t  w_iq;

    // A held symbol may be replaced only in the cycle it is taken.
    assign w_ready  = !r_valid || Ready_out;
    assign w_accept = Valid_in && w_ready;
    assign w_load   = w_accept && r_phase;

    qpsk_mapper u_map (
        .i_b0 (r_b0),
        .i_b1 (Data_in),
        .o_iq (w_iq)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_phase <= 1'b0;
            r_b0    <= 1'b0;
            r_valid <= 1'b0;
            r_iq    <= '0;
        end else begin
            if (w_accept) begin
                r_phase <= ~r_phase;
            end
            if (w_accept && !r_phase) begin
                r_b0 <= Data_in;
            end
            if (w_load) begin
                r_iq    <= w_iq;
                r_valid <= 1'b1;
            end else if (Ready_out && r_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Ready_in  = w_ready;
    assign Valid_out = r_valid;

`ifdef MODULATOR_ZERO_IDLE_EN
    assign I = r_valid ? r_iq.i : '0;
    assign Q = r_valid ? r_iq.q : '0;
`else
    assign I = r_iq.i;
    assign Q = r_iq.q;
`endif

endmodule

// File: tb/tb_modulator.sv
// Self-checking bench for the QPSK modulator.
// Reference: bit-pair queue and symbol list derived from the mapping table.
module tb_modulator;

    logic        clk;
    logic        rstn;
    logic        Valid_in;
    logic        Data_in;
    logic        Ready_in;
    logic        Ready_out;
    logic        Valid_out;
    logic [15:0] I;
    logic [15:0] Q;

    int total = 0;
    int bad   = 0;

    logic        m_valid;
    logic [31:0] m_sym;
    logic        pend[$];
    logic [31:0] out_q[$];
    logic        blk[192];

    modulator dut (
        .clk       (clk),
        .rstn      (rstn),
        .Valid_in  (Valid_in),
        .Data_in   (Data_in),
        .Ready_in  (Ready_in),
        .Ready_out (Ready_out),
        .Valid_out (Valid_out),
        .I         (I),
        .Q         (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lvl(input logic b);
        return b ? 16'hA581 : 16'h5A7F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        logic [15:0] ei;
        logic [15:0] eq;
        ei = m_sym[31:16];
        eq = m_sym[15:0];
`ifdef MODULATOR_ZERO_IDLE_EN
        if (!m_valid) begin
            ei = 16'h0;
            eq = 16'h0;
        end
`endif
        check("valid_out", {31'b0, Valid_out}, {31'b0, m_valid});
        check("i_out", {16'b0, I}, {16'b0, ei});
        check("q_out", {16'b0, Q}, {16'b0, eq});
    endtask

    task automatic step(input logic v, input logic d, input logic ro);
        logic exp_rdy;
        logic acc;
        logic ld;
        logic b0;
        @(negedge clk);
        Valid_in  = v;
        Data_in   = d;
        Ready_out = ro;
        #1;
        exp_rdy = !m_valid || ro;
        check("ready_in", {31'b0, Ready_in}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        ld = 1'b0;
        if (ro && m_valid) out_q.push_back(m_sym);
        if (acc) begin
            if (pend.size() == 0) begin
                pend.push_back(d);
            end else begin
                b0    = pend.pop_front();
                m_sym = {lvl(b0), lvl(d)};
                ld    = 1'b1;
            end
        end
        if (ld) m_valid = 1'b1;
        else if (ro && m_valid) m_valid = 1'b0;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b1;
        Valid_in  = 1'b0;
        Data_in   = 1'b0;
        Ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_sym   = '0;
        pend.delete();
        check("rst_valid", {31'b0, Valid_out}, 32'd0);
        check("rst_i", {16'b0, I}, 32'd0);
        check("rst_q", {16'b0, Q}, 32'd0);
        check("rst_ready", {31'b0, Ready_in}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    initial begin
        logic [31:0] head;
        logic [15:0] tail;
        rstn      = 1'b0;
        Valid_in  = 1'b0;
        Data_in   = 1'b0;
        Ready_out = 1'b0;
        m_valid   = 1'b0;
        m_sym     = '0;

        do_reset();

        head = 32'h4B047DFA;
        tail = 16'hBD1E;
        for (int i = 0; i < 192; i++) blk[i] = 1'($urandom);
        for (int i = 0; i < 32; i++) blk[i] = head[31-i];
        for (int i = 0; i < 16; i++) blk[176+i] = tail[15-i];

        for (int b = 0; b < 3; b++) begin
            out_q.delete();
            for (int i = 0; i < 192; i++) step(1'b1, blk[i], 1'b1);
            step(1'b0, 1'b0, 1'b1);
            check("blk_count", out_q.size(), 32'd96);
            for (int k = 0; k < 96 && k < out_q.size(); k++)
                check("blk_sym", out_q[k],
                      {lvl(blk[2*k]), lvl(blk[2*k+1])});
            if (b == 0 && out_q.size() >= 4) begin
                check("first0", out_q[0], 32'h5A7FA581);
                check("first1", out_q[1], 32'h5A7F5A7F);
                check("first2", out_q[2], 32'hA5815A7F);
                check("first3", out_q[3], 32'hA581A581);
            end
        end

        out_q.delete();
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("stall_b0_novalid", {31'b0, Valid_out}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("stall_b0_sym", {I, Q}, 32'hA5815A7F);

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        check("bp_held", {I, Q}, 32'hA581A581);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("bp_count", out_q.size(), 32'd3);
        if (out_q.size() >= 3) begin
            check("bp_sym0", out_q[0], 32'hA5815A7F);
            check("bp_sym1", out_q[1], 32'hA581A581);
            check("bp_sym2", out_q[2], 32'h5A7FA581);
        end

        for (int i = 0; i < 300; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        step(1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        check("rst_mid_novalid", {31'b0, Valid_out}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_mid_sym", {I, Q}, 32'h5A7F5A7F);
        check("rst_mid_valid", {31'b0, Valid_out}, 32'd1);
        step(1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
